id_ex_stage: RTL and testbench

- ID/EX pipeline register and EX-stage operand network. Sits directly upstream of the ALU.
- Latches decoded fields from ID and resolves RAW hazards by forwarding from EX/MEM and MEM/WB.
- Drives alu_ctrl/op_A/op_B into the ALU, plus the branch target and store data.
- Detects load-use hazards, inserts bubbles itself, and honours downstream stall and redirect flush.

---
 rtl/id_ex_stage_pkg.sv | 52 +++++
 rtl/id_ex_stage_fwd_mux.sv | 32 +++
 rtl/id_ex_stage.sv | 170 +++++++++++++++++
 tb/tb_id_ex_stage.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_ex_stage_pkg.sv
// Shared encodings for the ID/EX stage: ALU op codes, operand selects and
// the control word carried in the ID/EX register, including its bubble value.
package id_ex_stage_pkg;

    localparam logic [3:0] ALU_ADD  = 4'h0;
    localparam logic [3:0] ALU_SUB  = 4'h1;
    localparam logic [3:0] ALU_AND  = 4'h2;
    localparam logic [3:0] ALU_OR   = 4'h3;
    localparam logic [3:0] ALU_XOR  = 4'h4;
    localparam logic [3:0] ALU_SLL  = 4'h5;
    localparam logic [3:0] ALU_SRL  = 4'h6;
    localparam logic [3:0] ALU_SRA  = 4'h7;
    localparam logic [3:0] ALU_SLT  = 4'h8;
    localparam logic [3:0] ALU_SLTU = 4'h9;

    localparam logic [1:0] A_SEL_RS1  = 2'd0;
    localparam logic [1:0] A_SEL_PC   = 2'd1;
    localparam logic [1:0] A_SEL_ZERO = 2'd2;

    localparam logic [1:0] B_SEL_RS2  = 2'd0;
    localparam logic [1:0] B_SEL_IMM  = 2'd1;
    localparam logic [1:0] B_SEL_FOUR = 2'd2;

    typedef struct packed {
        logic       valid;
        logic       reg_we;
        logic       mem_re;
        logic       mem_we;
        logic       is_jalr;
        logic [4:0] rd_addr;
        logic [3:0] alu_ctrl;
        logic [1:0] a_sel;
        logic [1:0] b_sel;
        logic [4:0] rs1_addr;
        logic [4:0] rs2_addr;
    } ex_ctrl_t;

    localparam ex_ctrl_t BUBBLE_CTRL = '{
        valid:    1'b0,
        reg_we:   1'b0,
        mem_re:   1'b0,
        mem_we:   1'b0,
        is_jalr:  1'b0,
        rd_addr:  5'd0,
        alu_ctrl: ALU_ADD,
        a_sel:    A_SEL_RS1,
        b_sel:    B_SEL_RS2,
        rs1_addr: 5'd0,
        rs2_addr: 5'd0
    };

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// Per-source operand forwarding: EX/MEM beats MEM/WB, which beats the
// registered regfile value; x0 is never forwarded.
module id_ex_stage_fwd_mux #(
    parameter int XLEN = 32
) (
    input  logic [4:0]      rs_addr_i,
    input  logic [XLEN-1:0] rs_data_i,
    input  logic            exm_we_i,
    input  logic [4:0]      exm_rd_i,
    input  logic [XLEN-1:0] exm_data_i,
    input  logic            mwb_we_i,
    input  logic [4:0]      mwb_rd_i,
    input  logic [XLEN-1:0] mwb_data_i,
    output logic [XLEN-1:0] fwd_data_o
);

    logic exm_hit;
    logic mwb_hit;

    assign exm_hit = exm_we_i && (exm_rd_i != 5'd0) && (exm_rd_i == rs_addr_i);
    assign mwb_hit = mwb_we_i && (mwb_rd_i != 5'd0) && (mwb_rd_i == rs_addr_i);

    always_comb begin
        fwd_data_o = rs_data_i;
        if (exm_hit) begin
            fwd_data_o = exm_data_i;
        end else if (mwb_hit) begin
            fwd_data_o = mwb_data_i;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, stall hold with
// write-back snoop, and the forwarded operand network feeding the ALU.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            stall,
    input  logic            flush,
    input  logic            id_valid,
    input  logic [XLEN-1:0] id_pc,
    input  logic [XLEN-1:0] id_imm,
    input  logic [4:0]      id_rs1_addr,
    input  logic [4:0]      id_rs2_addr,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic            id_use_rs1,
    input  logic            id_use_rs2,
    input  logic [4:0]      id_rd_addr,
    input  logic            id_reg_we,
    input  logic            id_mem_re,
    input  logic            id_mem_we,
    input  logic            id_is_jalr,
    input  logic [3:0]      id_alu_ctrl,
    input  logic [1:0]      id_a_sel,
    input  logic [1:0]      id_b_sel,
    input  logic            exm_we,
    input  logic [4:0]      exm_rd,
    input  logic [XLEN-1:0] exm_data,
    input  logic            mwb_we,
    input  logic [4:0]      mwb_rd,
    input  logic [XLEN-1:0] mwb_data,
    output logic            load_use_stall,
    output logic            ex_valid,
    output logic            ex_reg_we,
    output logic            ex_mem_re,
    output logic            ex_mem_we,
    output logic [4:0]      ex_rd_addr,
    output logic [XLEN-1:0] ex_pc,
    output logic [3:0]      alu_ctrl,
    output logic [XLEN-1:0] op_A,
    output logic [XLEN-1:0] op_B,
    output logic [XLEN-1:0] ex_store_data,
    output logic [XLEN-1:0] ex_br_target
);

    ex_ctrl_t        ctrl_q, ctrl_d, id_ctrl;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] imm_q, imm_d;
    logic [XLEN-1:0] rs1_data_q, rs1_data_d;
    logic [XLEN-1:0] rs2_data_q, rs2_data_d;
    logic [XLEN-1:0] rs1_fwd, rs2_fwd;
    logic [XLEN-1:0] br_base, br_sum;
    logic            rs1_raw, rs2_raw;

    assign id_ctrl = '{
        valid:    id_valid,
        reg_we:   id_reg_we,
        mem_re:   id_mem_re,
        mem_we:   id_mem_we,
        is_jalr:  id_is_jalr,
        rd_addr:  id_rd_addr,
        alu_ctrl: id_alu_ctrl,
        a_sel:    id_a_sel,
        b_sel:    id_b_sel,
        rs1_addr: id_rs1_addr,
        rs2_addr: id_rs2_addr
    };

    assign rs1_raw = id_use_rs1 && (id_rs1_addr == ctrl_q.rd_addr);
    assign rs2_raw = id_use_rs2 && (id_rs2_addr == ctrl_q.rd_addr);
    assign load_use_stall = ctrl_q.valid && ctrl_q.mem_re && (ctrl_q.rd_addr != 5'd0)
                          && (rs1_raw || rs2_raw) && id_valid && !flush;

    always_comb begin
        ctrl_d     = ctrl_q;
        pc_d       = pc_q;
        imm_d      = imm_q;
        rs1_data_d = rs1_data_q;
        rs2_data_d = rs2_data_q;
        if (flush || (!stall && load_use_stall)) begin
            ctrl_d     = BUBBLE_CTRL;
            pc_d       = RESET_PC;
            imm_d      = '0;
            rs1_data_d = '0;
            rs2_data_d = '0;
        end else if (stall) begin
            // A producer retiring from MEM/WB during the hold would otherwise be lost.
            if (mwb_we && (mwb_rd != 5'd0) && (mwb_rd == ctrl_q.rs1_addr)) rs1_data_d = mwb_data;
            if (mwb_we && (mwb_rd != 5'd0) && (mwb_rd == ctrl_q.rs2_addr)) rs2_data_d = mwb_data;
        end else begin
            ctrl_d     = id_ctrl;
            pc_d       = id_pc;
            imm_d      = id_imm;
            rs1_data_d = id_rs1_data;
            rs2_data_d = id_rs2_data;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ctrl_q     <= BUBBLE_CTRL;
            pc_q       <= RESET_PC;
            imm_q      <= '0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
        end else begin
            ctrl_q     <= ctrl_d;
            pc_q       <= pc_d;
            imm_q      <= imm_d;
            rs1_data_q <= rs1_data_d;
            rs2_data_q <= rs2_data_d;
        end
    end

    id_ex_stage_fwd_mux #(.XLEN(XLEN)) u_fwd_rs1 (
        .rs_addr_i  (ctrl_q.rs1_addr),
        .rs_data_i  (rs1_data_q),
        .exm_we_i   (exm_we),
        .exm_rd_i   (exm_rd),
        .exm_data_i (exm_data),
        .mwb_we_i   (mwb_we),
        .mwb_rd_i   (mwb_rd),
        .mwb_data_i (mwb_data),
        .fwd_data_o (rs1_fwd)
    );

    id_ex_stage_fwd_mux #(.XLEN(XLEN)) u_fwd_rs2 (
        .rs_addr_i  (ctrl_q.rs2_addr),
        .rs_data_i  (rs2_data_q),
        .exm_we_i   (exm_we),
        .exm_rd_i   (exm_rd),
        .exm_data_i (exm_data),
        .mwb_we_i   (mwb_we),
        .mwb_rd_i   (mwb_rd),
        .mwb_data_i (mwb_data),
        .fwd_data_o (rs2_fwd)
    );

    always_comb begin
        case (ctrl_q.a_sel)
            A_SEL_PC:   op_A = pc_q;
            A_SEL_ZERO: op_A = '0;
            default:    op_A = rs1_fwd;
        endcase
        case (ctrl_q.b_sel)
            B_SEL_IMM:  op_B = imm_q;
            B_SEL_FOUR: op_B = XLEN'(4);
            default:    op_B = rs2_fwd;
        endcase
    end

    // jalr clears bit 0 after the add, so the sum is formed first.
    assign br_base      = ctrl_q.is_jalr ? rs1_fwd : pc_q;
    assign br_sum       = br_base + imm_q;
    assign ex_br_target = ctrl_q.is_jalr ? {br_sum[XLEN-1:1], 1'b0} : br_sum;

    assign ex_valid      = ctrl_q.valid;
    assign ex_reg_we     = ctrl_q.reg_we;
    assign ex_mem_re     = ctrl_q.mem_re;
    assign ex_mem_we     = ctrl_q.mem_we;
    assign ex_rd_addr    = ctrl_q.rd_addr;
    assign ex_pc         = pc_q;
    assign alu_ctrl      = ctrl_q.alu_ctrl;
    assign ex_store_data = rs2_fwd;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against an instruction-level model.
module tb_id_ex_stage;
  import id_ex_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        stall, flush, id_valid;
  logic [31:0] id_pc, id_imm, id_rs1_data, id_rs2_data;
  logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
  logic        id_use_rs1, id_use_rs2, id_reg_we, id_mem_re, id_mem_we, id_is_jalr;
  logic [3:0]  id_alu_ctrl;
  logic [1:0]  id_a_sel, id_b_sel;
  logic        exm_we, mwb_we;
  logic [4:0]  exm_rd, mwb_rd;
  logic [31:0] exm_data, mwb_data;
  logic        load_use_stall, ex_valid, ex_reg_we, ex_mem_re, ex_mem_we;
  logic [4:0]  ex_rd_addr;
  logic [31:0] ex_pc, op_A, op_B, ex_store_data, ex_br_target;
  logic [3:0]  alu_ctrl;

  int total = 0;
  int bad = 0;
  logic chk_en = 1'b0;

  id_ex_stage #(.XLEN(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .rstn(rstn), .stall(stall), .flush(flush),
    .id_valid(id_valid), .id_pc(id_pc), .id_imm(id_imm),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd_addr(id_rd_addr),
    .id_reg_we(id_reg_we), .id_mem_re(id_mem_re), .id_mem_we(id_mem_we),
    .id_is_jalr(id_is_jalr), .id_alu_ctrl(id_alu_ctrl),
    .id_a_sel(id_a_sel), .id_b_sel(id_b_sel),
    .exm_we(exm_we), .exm_rd(exm_rd), .exm_data(exm_data),
    .mwb_we(mwb_we), .mwb_rd(mwb_rd), .mwb_data(mwb_data),
    .load_use_stall(load_use_stall), .ex_valid(ex_valid), .ex_reg_we(ex_reg_we),
    .ex_mem_re(ex_mem_re), .ex_mem_we(ex_mem_we), .ex_rd_addr(ex_rd_addr),
    .ex_pc(ex_pc), .alu_ctrl(alu_ctrl), .op_A(op_A), .op_B(op_B),
    .ex_store_data(ex_store_data), .ex_br_target(ex_br_target)
  );

  // clock
  always #5 clk = ~clk;

  // model: the instruction currently sitting in EX, as a plain record
  typedef struct {
    logic        v, we, re, mwe, jalr;
    logic [4:0]  rd, r1, r2;
    logic [3:0]  alu;
    logic [1:0]  as, bs;
    logic [31:0] pc, imm, d1, d2;
  } slot_t;

  slot_t m;
  logic [44:0] exp_q[$];

  function automatic slot_t empty_slot();
    slot_t s;
    s.v = 0; s.we = 0; s.re = 0; s.mwe = 0; s.jalr = 0;
    s.rd = 0; s.r1 = 0; s.r2 = 0; s.alu = ALU_ADD; s.as = 0; s.bs = 0;
    s.pc = 32'h0; s.imm = 0; s.d1 = 0; s.d2 = 0;
    return s;
  endfunction

  function automatic logic [31:0] m_fwd(input logic [4:0] a, input logic [31:0] d);
    if (a != 0 && exm_we && exm_rd == a) return exm_data;
    if (a != 0 && mwb_we && mwb_rd == a) return mwb_data;
    return d;
  endfunction

  function automatic logic m_lus(input slot_t s);
    logic dep;
    dep = (id_use_rs1 && id_rs1_addr == s.rd) || (id_use_rs2 && id_rs2_addr == s.rd);
    return s.v && s.re && s.rd != 0 && dep && id_valid && !flush;
  endfunction

  function automatic logic [44:0] reg_word(input slot_t s);
    return {s.v, s.we, s.re, s.mwe, s.rd, s.alu, s.pc};
  endfunction

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m = empty_slot();
      exp_q.delete();
    end else begin
      if (flush) begin
        m = empty_slot();
      end else if (stall) begin
        if (mwb_we && mwb_rd != 0 && mwb_rd == m.r1) m.d1 = mwb_data;
        if (mwb_we && mwb_rd != 0 && mwb_rd == m.r2) m.d2 = mwb_data;
      end else if (m_lus(m)) begin
        m = empty_slot();
      end else begin
        m.v = id_valid; m.we = id_reg_we; m.re = id_mem_re; m.mwe = id_mem_we;
        m.jalr = id_is_jalr; m.rd = id_rd_addr; m.r1 = id_rs1_addr; m.r2 = id_rs2_addr;
        m.alu = id_alu_ctrl; m.as = id_a_sel; m.bs = id_b_sel;
        m.pc = id_pc; m.imm = id_imm; m.d1 = id_rs1_data; m.d2 = id_rs2_data;
      end
      exp_q.push_back(reg_word(m));
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // scoreboard: every cycle, mid-cycle, once outputs have settled
  always @(negedge clk) begin
    logic [44:0] w;
    logic [31:0] f1, f2, ea, eb, s;
    if (exp_q.size() > 0) begin
      w = exp_q.pop_front();
      if (chk_en && rstn) begin
        f1 = m_fwd(m.r1, m.d1);
        f2 = m_fwd(m.r2, m.d2);
        ea = (m.as == 2'd1) ? m.pc : (m.as == 2'd2) ? 32'h0 : f1;
        eb = (m.bs == 2'd1) ? m.imm : (m.bs == 2'd2) ? 32'd4 : f2;
        s  = (m.jalr ? f1 : m.pc) + m.imm;
        if (m.jalr) s[0] = 1'b0;
        chk("regs", {ex_valid, ex_reg_we, ex_mem_re, ex_mem_we, ex_rd_addr, alu_ctrl, ex_pc}, w);
        chk("lus", load_use_stall, m_lus(m));
        chk("op_A", op_A, ea);
        chk("op_B", op_B, eb);
        chk("store", ex_store_data, f2);
        chk("br", ex_br_target, s);
      end
    end
  end

  // driver tasks
  task automatic clr_in();
    stall = 0; flush = 0; id_valid = 0; id_pc = 0; id_imm = 0;
    id_rs1_addr = 0; id_rs2_addr = 0; id_rs1_data = 0; id_rs2_data = 0;
    id_use_rs1 = 0; id_use_rs2 = 0; id_rd_addr = 0; id_reg_we = 0; id_mem_re = 0;
    id_mem_we = 0; id_is_jalr = 0; id_alu_ctrl = 0; id_a_sel = 0; id_b_sel = 0;
    exm_we = 0; exm_rd = 0; exm_data = 0; mwb_we = 0; mwb_rd = 0; mwb_data = 0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_in();
    stall = ($urandom_range(0, 4) == 0);
    flush = ($urandom_range(0, 9) == 0);
    id_valid = ($urandom_range(0, 4) != 0);
    id_pc = $urandom; id_imm = $urandom;
    id_rs1_addr = 5'($urandom_range(0, 7)); id_rs2_addr = 5'($urandom_range(0, 7));
    id_rs1_data = $urandom; id_rs2_data = $urandom;
    id_use_rs1 = 1'($urandom_range(0, 1)); id_use_rs2 = 1'($urandom_range(0, 1));
    id_rd_addr = 5'($urandom_range(0, 7)); id_reg_we = 1'($urandom_range(0, 1));
    id_mem_re = ($urandom_range(0, 2) == 0); id_mem_we = ($urandom_range(0, 3) == 0);
    id_is_jalr = ($urandom_range(0, 3) == 0); id_alu_ctrl = 4'($urandom_range(0, 15));
    id_a_sel = 2'($urandom_range(0, 3)); id_b_sel = 2'($urandom_range(0, 3));
    exm_we = 1'($urandom_range(0, 1)); exm_rd = 5'($urandom_range(0, 7)); exm_data = $urandom;
    mwb_we = 1'($urandom_range(0, 1)); mwb_rd = 5'($urandom_range(0, 7)); mwb_data = $urandom;
  endtask

  initial begin
    clr_in();
    // reset state
    #2;
    chk("rst_valid", ex_valid, 1'b0);
    chk("rst_pc", ex_pc, 32'h0);
    chk("rst_alu", alu_ctrl, 4'h0);
    chk("rst_opA", op_A, 32'h0);
    chk("rst_opB", op_B, 32'h0);
    chk("rst_lus", load_use_stall, 1'b0);
    #10;
    rstn = 1'b1;
    chk_en = 1'b1;

    // forwarding: x0 never forwarded
    cyc();
    id_valid = 1; id_rs1_addr = 0; id_rs1_data = 32'h11; id_use_rs1 = 1;
    cyc();
    id_valid = 0; stall = 1;
    exm_we = 1; exm_rd = 0; exm_data = 32'h22; mwb_we = 1; mwb_rd = 0; mwb_data = 32'h33;
    @(negedge clk);
    chk("fwd_x0", op_A, 32'h11);
    cyc();
    // forwarding priority on x5
    stall = 0; id_valid = 1; id_rs1_addr = 5; id_rs1_data = 32'h11; exm_we = 0; mwb_we = 0;
    cyc();
    stall = 1; id_valid = 0;
    exm_we = 1; exm_rd = 5; exm_data = 32'h22; mwb_we = 1; mwb_rd = 5; mwb_data = 32'h33;
    @(negedge clk);
    chk("fwd_exm", op_A, 32'h22);
    exm_we = 0;
    #1;
    chk("fwd_mwb", op_A, 32'h33);

    // load-use
    cyc(); clr_in();
    cyc();
    id_valid = 1; id_rd_addr = 7; id_reg_we = 1; id_mem_re = 1;
    cyc();
    id_mem_re = 0; id_rd_addr = 8; id_rs2_addr = 7; id_use_rs2 = 1;
    @(negedge clk);
    chk("lu_stall", load_use_stall, 1'b1);
    cyc();
    @(negedge clk);
    chk("lu_bub_valid", ex_valid, 1'b0);
    chk("lu_bub_we", ex_reg_we, 1'b0);
    cyc();
    @(negedge clk);
    chk("lu_cap_valid", ex_valid, 1'b1);
    chk("lu_cap_rd", ex_rd_addr, 5'd8);

    // write-back snoop across a 3-cycle stall
    cyc(); clr_in();
    cyc();
    id_valid = 1; id_rs2_addr = 9; id_rs2_data = 32'h1; id_use_rs2 = 1; id_mem_we = 1;
    cyc();
    stall = 1; id_valid = 0; id_rs2_addr = 3; id_rs2_data = 32'h55;
    cyc();
    mwb_we = 1; mwb_rd = 9; mwb_data = 32'hABCD;
    cyc();
    mwb_we = 0;
    cyc();
    stall = 0;
    @(negedge clk);
    chk("snoop", ex_store_data, 32'hABCD);

    // stall holds, flush beats stall
    cyc(); clr_in();
    cyc();
    id_valid = 1; id_pc = 32'h40; id_rd_addr = 3; id_alu_ctrl = 4'h2; id_reg_we = 1;
    cyc();
    stall = 1; id_pc = 32'h80; id_rd_addr = 4;
    cyc();
    @(negedge clk);
    chk("hold_valid", ex_valid, 1'b1);
    chk("hold_pc", ex_pc, 32'h40);
    chk("hold_rd", ex_rd_addr, 5'd3);
    chk("hold_alu", alu_ctrl, 4'h2);
    flush = 1;
    cyc();
    @(negedge clk);
    chk("flush_valid", ex_valid, 1'b0);
    chk("flush_pc", ex_pc, 32'h0);
    chk("flush_alu", alu_ctrl, ALU_ADD);

    // branch targets
    cyc(); clr_in();
    cyc();
    id_valid = 1; id_is_jalr = 1; id_rs1_addr = 3; id_rs1_data = 32'h1001; id_use_rs1 = 1;
    id_imm = 32'h4; id_pc = 32'h2000;
    cyc();
    id_is_jalr = 0; id_pc = 32'hFFFF_FFFC; id_imm = 32'h8; id_b_sel = 2'd2;
    @(negedge clk);
    chk("jalr_tgt", ex_br_target, 32'h1004);
    cyc();
    @(negedge clk);
    chk("wrap_tgt", ex_br_target, 32'h4);
    chk("bsel4", op_B, 32'h4);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      cyc();
      rand_in();
    end

    // asynchronous reset while EX holds a valid instruction
    cyc(); clr_in();
    id_valid = 1; id_pc = 32'h100; id_rd_addr = 6; id_alu_ctrl = 4'h3; id_reg_we = 1; id_mem_we = 1;
    cyc();
    clr_in();
    chk("pre_rst_valid", ex_valid, 1'b1);
    #2;
    chk_en = 0;
    rstn = 0;
    #1;
    chk("arst_valid", ex_valid, 1'b0);
    chk("arst_we", ex_reg_we, 1'b0);
    chk("arst_mwe", ex_mem_we, 1'b0);
    chk("arst_rd", ex_rd_addr, 5'd0);
    chk("arst_pc", ex_pc, 32'h0);
    chk("arst_alu", alu_ctrl, 4'h0);
    @(negedge clk);
    #1;
    rstn = 1;
    chk_en = 1;
    for (int i = 0; i < 20; i++) begin
      cyc();
      rand_in();
    end
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
